// File: rtl/uart_word_rx.sv
// 8N1 UART receiver that assembles little-endian DATA_WIDTH-bit words and
// presents them on a valid/ready stream through a 2-entry FIFO.
module uart_word_rx #(
  parameter int unsigned CLK_SPEED    = 40_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned IDLE_TIMEOUT = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx_in,
  output logic                  m_axi_valid,
  input  logic                  m_axi_ready,
  output logic [DATA_WIDTH-1:0] m_axi_data,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int unsigned DIV   = CLK_SPEED / BAUD;
  localparam int unsigned HALF  = DIV / 2;
  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned CW    = $clog2(DIV);
  localparam int unsigned BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned TW    = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                state;
  logic                  rx_m, rx_s, rx_p;
  logic [CW-1:0]         cnt;
  logic [2:0]            bit_idx;
  logic [7:0]            shift;
  logic [BW-1:0]         byte_idx;
  logic [TW-1:0]         to_cnt;
  logic [DATA_WIDTH-1:0] word_buf, assembled, push_word;
  logic                  push_req;
  logic                  bit_end, byte_last;

  logic [DATA_WIDTH-1:0] mem [0:1];
  logic                  rd_ptr, wr_ptr;
  logic [1:0]            count;
  logic                  pop, push_ok;

  assign bit_end   = (cnt == CW'(DIV - 1));
  assign byte_last = (byte_idx == BW'(BYTES - 1));

  always_comb begin
    assembled = word_buf;
    for (int unsigned k = 0; k < BYTES; k++)
      if (byte_idx == BW'(k)) assembled[8*k +: 8] = shift;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_p <= 1'b1;
    end else begin
      rx_m <= rx_in;
      rx_s <= rx_m;
      rx_p <= rx_s;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      byte_idx  <= '0;
      to_cnt    <= '0;
      word_buf  <= '0;
      push_word <= '0;
      push_req  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      push_req  <= 1'b0;
      frame_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (!rx_s && rx_p) begin
            cnt    <= '0;
            to_cnt <= '0;
            state  <= S_START;
          end else begin
            // The bit counter keeps free-running here to pace the idle timeout.
            cnt <= bit_end ? '0 : cnt + 1'b1;
            if (byte_idx == '0) begin
              to_cnt <= '0;
            end else if (bit_end) begin
              if (to_cnt == TW'(IDLE_TIMEOUT - 1)) begin
                to_cnt   <= '0;
                byte_idx <= '0;
              end else begin
                to_cnt <= to_cnt + 1'b1;
              end
            end
          end
        end
        S_START: begin
          if (cnt == CW'(HALF - 1)) begin
            cnt <= '0;
            if (!rx_s) begin
              bit_idx <= '0;
              state   <= S_DATA;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= S_IDLE;
            if (rx_s) begin
              word_buf <= assembled;
              if (byte_last) begin
                push_word <= assembled;
                push_req  <= 1'b1;
                byte_idx  <= '0;
              end else begin
                byte_idx <= byte_idx + 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              byte_idx  <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign m_axi_valid = (count != 2'd0);
  assign m_axi_data  = mem[rd_ptr];
  assign pop         = m_axi_valid && m_axi_ready;
  assign push_ok     = push_req && ((count != 2'd2) || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push_req && (count == 2'd2) && !pop;
      if (push_ok) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({push_ok, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/uart_word_rx.md
# uart_word_rx

Serial front end that feeds the panel pipeline's 32-bit stream input. It receives 8N1 UART bytes on a single line and assembles them little-endian into `DATA_WIDTH`-bit words. Words are presented on a valid/ready master stream through a 2-entry output FIFO. It sits directly upstream of the memory loader and drives its `s_axi_valid` / `s_axi_ready` / `s_axi_data` handshake in the `clk` domain.

## Interface
- `CLK_SPEED`, 40_000_000, `clk` frequency in Hz.
- `BAUD`, 115_200, line rate in bit/s.
  - `DIV = CLK_SPEED/BAUD`, truncated; must be ≥ 4.
  - `HALF = DIV/2`, truncated.
- `DATA_WIDTH`, 32, output word width; must be a multiple of 8.
  - `BYTES = DATA_WIDTH/8`.
- `IDLE_TIMEOUT`, 20, idle bit-periods after which a partially assembled word is discarded.

Ports:
- `clk`, input, 1: sole clock.
- `reset_n`, input, 1: reset, asynchronous, active-low.
- `rx_in`, input, 1: asynchronous UART line, idle high.
- `m_axi_valid`, output, 1: output FIFO non-empty.
- `m_axi_ready`, input, 1: downstream accepts the head word.
- `m_axi_data`, output, `DATA_WIDTH`: head word of the output FIFO.
- `frame_err`, output, 1: one-cycle pulse on a bad stop bit.
- `overrun`, output, 1: one-cycle pulse when a completed word is dropped.

## Operation
- `rx_in` passes through a 2-FF synchronizer. Both FFs reset to 1. The result is `rx_s`; `rx_p` is `rx_s` delayed one cycle.
- A single bit counter (`DIV` range) drives all bit timing. The FSM is below.
  - **IDLE**: if `rx_s==0 && rx_p==1`, clear the counter and go to START.
  - **START**: when the counter reaches `HALF-1`, sample `rx_s`.
    - 0: go to DATA with the counter cleared and bit index 0.
    - 1: glitch; return to IDLE and record nothing.
  - **DATA**: every `DIV` cycles, sample `rx_s` into the shift register, LSB first. After bit 7, go to STOP.
  - **STOP**: after `DIV` cycles, sample `rx_s`.
    - 1: the byte is accepted.
    - 0: pulse `frame_err`, discard the byte and all partial-word bytes (byte index := 0).
    - In both cases return to IDLE. A line held low does not retrigger until it has gone high, then falls.
- Word assembly:
  - Byte k (k = 0..BYTES-1) goes to bits `[8k+7:8k]`.
  - On acceptance of byte `BYTES-1`, the completed word is pushed and the byte index wraps to 0.
- Idle timeout:
  - Applies while the FSM is in IDLE with byte index ≠ 0.
  - It counts bit periods. At `IDLE_TIMEOUT`, the partial bytes are discarded (index := 0) without an error pulse.
  - Any start detection clears the timeout count.
- Output FIFO, 2 entries:
  - `m_axi_valid = (count != 0)`; `m_axi_data` = head entry.
  - A pop happens when `m_axi_valid && m_axi_ready`.
  - A push with count < 2, or with count == 2 and a simultaneous pop, is accepted.
  - A push with count == 2 and no pop drops the new word and pulses `overrun`. Stored words are unchanged.
  - The head word stays stable while `m_axi_valid && !m_axi_ready`.

## Timing
- Reset values:
  - `m_axi_valid`=0, `m_axi_data`=0, `frame_err`=0, `overrun`=0.
  - FIFO empty, FSM in IDLE, byte index 0, synchronizer = 1.
- Reset asserted mid-byte or mid-word aborts everything immediately. There is no partial output after release.
- Start detection latency: 2 sync cycles + 1 edge-detect cycle after the line falls.
- The start bit is sampled `HALF` cycles after detection. Data bit n is sampled `HALF+(n+1)·DIV` cycles after detection, and the stop bit at `HALF+9·DIV`.
- A word is pushed the cycle after the last stop-bit sample. `m_axi_valid` rises on the following cycle (registered FIFO count).
- `frame_err` and `overrun` are registered, high for exactly one `clk` cycle.
- Throughput: 1 word per `BYTES`·10 bit-times. A single FIFO entry would suffice at steady state; the second entry absorbs `m_axi_ready` stalls of up to one word time.

## Test plan
Parameters for all scenarios: `CLK_SPEED`=1_600_000, `BAUD`=100_000 (`DIV`=16, `HALF`=8), `DATA_WIDTH`=32, `IDLE_TIMEOUT`=20.
- Send 0x78, 0x56, 0x34, 0x12 with `m_axi_ready`=1 → exactly one beat, `m_axi_data`=0x12345678; `frame_err`/`overrun` stay 0.
- With `m_axi_ready`=0, send words 0xA0A1A2A3, 0xB0B1B2B3, 0xC0C1C2C3 → `overrun` pulses once, after the third word completes. Then with `m_axi_ready`=1 → beats 0xA0A1A2A3, then 0xB0B1B2B3, then `m_axi_valid`=0.
- Send 0x11, then 0x22 with stop bit 0 → `frame_err` pulses once. Then send 0x44, 0x33, 0x22, 0x11 → one beat 0x11223344.
- Drive `rx_in` low for 4 cycles, then high → no `frame_err`, no word; a following 4-byte word decodes correctly.
- Send 0xEE, 0xFF, then idle ≥ 21 bit periods, then send 0x04, 0x03, 0x02, 0x01 → one beat 0x01020304.
- Assert `reset_n` during bit 3 of byte 2 → all outputs 0 asynchronously. After release, a full 4-byte word decodes correctly.
